// File: rtl/uvw_seq_ctrl.sv
// ============================================================================
// Module   : uvw_seq_ctrl
// Purpose  : u/v/w counter sequencer; one shared adder, three slots per epoch
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uvw_seq_ctrl #(
  parameter int WIDTH = 3,
  parameter int EPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_u,
  input  logic [WIDTH-1:0] load_v,
  input  logic [WIDTH-1:0] load_w,
  output logic [WIDTH-1:0] u,
  output logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] w,
  output logic             busy,
  output logic             done,
  output logic [1:0]       phase,
  output logic [EPW-1:0]   epochs,
  output logic             prop_ok
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S_U  = 2'd1,
    S_V  = 2'd2,
    S_W  = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] u_q;
  logic [WIDTH-1:0] v_q;
  logic [WIDTH-1:0] w_q;
  logic             done_q;
  logic [EPW-1:0]   epochs_q;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] add_sum;

  // In IDLE the adder is free, so it also forms u+v for the safety flag.
  always_comb begin
    op_a = u_q;
    op_b = v_q;
    case (state_q)
      S_U: begin
        if (!((u_q < v_q) || (v_q < w_q))) begin
          op_a = v_q;
          op_b = C_ONE;
        end
      end
      S_V: begin
        op_a = v_q;
        op_b = C_ONE;
      end
      S_W: begin
        op_a = w_q;
        op_b = C_ONE;
      end
      default: begin
        op_a = u_q;
        op_b = v_q;
      end
    endcase
  end

  assign add_sum = op_a + op_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      u_q      <= C_ONE;
      v_q      <= C_ONE;
      w_q      <= C_ONE;
      done_q   <= 1'b0;
      epochs_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_en) begin
            u_q <= load_u;
            v_q <= load_v;
            w_q <= load_w;
          end else if (start) begin
            state_q <= S_U;
          end
        end
        S_U: begin
          u_q     <= add_sum;
          state_q <= S_V;
        end
        S_V: begin
          v_q     <= add_sum;
          state_q <= S_W;
        end
        S_W: begin
          w_q     <= add_sum;
          state_q <= IDLE;
          done_q  <= 1'b1;
          if (epochs_q != '1) begin
            epochs_q <= epochs_q + EPW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign u       = u_q;
  assign v       = v_q;
  assign w       = w_q;
  assign done    = done_q;
  assign epochs  = epochs_q;
  assign phase   = state_q;
  assign busy    = (state_q != IDLE);
  assign prop_ok = (state_q != IDLE) || (add_sum != C_ONE);

endmodule

`default_nettype wire

// File: tb/tb_uvw_seq_ctrl.sv
// ============================================================================
// Module   : tb_uvw_seq_ctrl
// Purpose  : scoreboard bench for uvw_seq_ctrl against an epoch-level model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uvw_seq_ctrl;

  localparam int WIDTH = 3;
  localparam int EPW   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             load_en = 1'b0;
  logic [WIDTH-1:0] load_u = '0;
  logic [WIDTH-1:0] load_v = '0;
  logic [WIDTH-1:0] load_w = '0;
  logic [WIDTH-1:0] u, v, w;
  logic             busy, done, prop_ok;
  logic [1:0]       phase;
  logic [EPW-1:0]   epochs;

  always #5 clk = ~clk;

  uvw_seq_ctrl #(.WIDTH(WIDTH), .EPW(EPW)) dut (
    .clk(clk), .rst(rst), .start(start), .load_en(load_en),
    .load_u(load_u), .load_v(load_v), .load_w(load_w),
    .u(u), .v(v), .w(w), .busy(busy), .done(done),
    .phase(phase), .epochs(epochs), .prop_ok(prop_ok)
  );

  typedef struct {
    logic [WIDTH-1:0] u, v, w;
    logic [EPW-1:0]   ep;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  // Architectural model: values change at epoch acceptance, visibility is
  // tracked by a remaining-cycle count for the three adder slots.
  logic [WIDTH-1:0] mu = 1, mv = 1, mw = 1;
  logic [EPW-1:0]   mep = 0, pend_ep = 0;
  int               cnt = 0;
  bit               mdone = 0;
  bit               mon_en = 0;
  logic [WIDTH-1:0] msum;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    mdone = 0;
    if (rst) begin
      if (cnt > 0) void'(sbq.pop_back());
      mu = 1; mv = 1; mw = 1;
      mep = 0;
      cnt = 0;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        mdone = 1;
        mep   = pend_ep;
      end
    end else if (load_en) begin
      mu = load_u; mv = load_v; mw = load_w;
    end else if (start) begin
      e.u = ((mu < mv) || (mv < mw)) ? WIDTH'(mu + mv) : WIDTH'(mv + 1);
      e.v = WIDTH'(mv + 1);
      e.w = WIDTH'(mw + 1);
      pend_ep = (mep == '1) ? mep : EPW'(mep + 1);
      e.ep = pend_ep;
      sbq.push_back(e);
      mu = e.u; mv = e.v; mw = e.w;
      cnt = 3;
    end
    #1;
  endtask

  task automatic do_load(input int a, input int b, input int c);
    load_en = 1; load_u = WIDTH'(a); load_v = WIDTH'(b); load_w = WIDTH'(c);
    step();
    load_en = 0;
  endtask

  task automatic run_epoch(input bit noise);
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      if (noise) begin
        start = 1; load_en = 1;
        load_u = WIDTH'($urandom); load_v = WIDTH'($urandom); load_w = WIDTH'($urandom);
      end
      step();
      start = 0; load_en = 0;
    end
    step();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      msum = mu + mv;
      chk("phase", phase, (cnt == 0) ? 0 : 4 - cnt);
      chk("busy", busy, (cnt != 0));
      chk("done", done, mdone);
      chk("epochs", epochs, mep);
      chk("prop_ok", prop_ok, (cnt != 0) || (msum != 1));
      if (cnt == 0) begin
        chk("idle_u", u, mu);
        chk("idle_v", v, mv);
        chk("idle_w", w, mw);
      end
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_u", u, e.u);
          chk("sb_v", v, e.v);
          chk("sb_w", w, e.w);
          chk("sb_epochs", epochs, e.ep);
        end
      end
    end
  end

  initial begin
    rst = 1;
    step();
    mon_en = 1;
    step();
    rst = 0;

    // single epoch from reset
    step();
    run_epoch(0);

    // back-to-back epochs with start held, wraps to 0
    rst = 1; step(); rst = 0;
    start = 1;
    repeat (28) step();
    start = 0;
    repeat (4) step();

    // u<v branch, then neither-condition branch, then prop violation
    do_load(1, 3, 0);
    run_epoch(1);
    do_load(5, 2, 1);
    run_epoch(1);
    do_load(0, 1, 4);
    step();

    // mid-epoch reset in S_V
    start = 1; step(); start = 0;
    step();
    rst = 1; step(); rst = 0;
    step();

    // load and start together: load wins
    load_en = 1; start = 1; load_u = 3; load_v = 6; load_w = 2;
    step();
    load_en = 0; start = 0;
    repeat (2) step();

    // saturation of the epoch counter
    rst = 1; step(); rst = 0;
    repeat (20) run_epoch(0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 59) == 0);
      start   = $urandom_range(0, 1);
      load_en = ($urandom_range(0, 3) == 0);
      load_u  = WIDTH'($urandom); load_v = WIDTH'($urandom); load_w = WIDTH'($urandom);
      step();
    end
    rst = 0; start = 0; load_en = 0;
    repeat (6) step();

    chk("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uvw_seq_ctrl.md
Name: uvw_seq_ctrl

Overview:
- Sequencing controller for the u/v/w counter datapath, built around one shared WIDTH-bit adder instead of three.
- Each requested update epoch is split into three ordered adder slots: u, then v, then w.
- The final values match the single-cycle update rule: u ← (u<v || v<w) ? u+v : v+1; v ← v+1; w ← w+1.
- Also provides a load port for configuring state, an epoch counter, and a safety flag for the model-checking property (u+v)!=1.

Parameters:
WIDTH, 3, width of u, v, w and of the shared adder
EPW, 4, width of the saturating completed-epoch counter

Ports:
clk  input  1  clock
rst  input  1  reset (synchronous, active-high)
start  input  1  request one update epoch; sampled only in IDLE
load_en  input  1  load u/v/w from load_* inputs; sampled only in IDLE
load_u  input  WIDTH  load value for u
load_v  input  WIDTH  load value for v
load_w  input  WIDTH  load value for w
u  output  WIDTH  u register
v  output  WIDTH  v register
w  output  WIDTH  w register
busy  output  1  epoch in progress (state ≠ IDLE)
done  output  1  one-cycle pulse after w is written
phase  output  2  state encoding: 0 IDLE, 1 S_U, 2 S_V, 3 S_W
epochs  output  EPW  completed epochs, saturating at all-ones
prop_ok  output  1  low iff in IDLE and (u+v) mod 2^WIDTH == 1

Behaviour:
- Reset (clk edge with rst=1) takes priority over everything, including mid-epoch:
  - u=v=w=1, state IDLE, busy=0, done=0, epochs=0.
  - Any partial epoch is abandoned.
- Arithmetic:
  - All additions are modulo 2^WIDTH; the carry is discarded.
  - Comparisons are unsigned.
  - A single adder instance is shared. Its operand mux is selected by state:
    - S_U: (u,v) if (u<v || v<w), else (v,1).
    - S_V: (v,1).
    - S_W: (w,1).
- FSM, all transitions on the clk edge:
  - IDLE, load_en=1: u,v,w ← load_u/v/w; stay in IDLE; start is ignored that cycle (load wins).
  - IDLE, start=1, load_en=0: go to S_U; registers unchanged.
  - S_U: u ← adder result; go to S_V. The comparison uses current v and w, which are still their pre-epoch values.
  - S_V: v ← adder result; go to S_W.
  - S_W: w ← adder result; go to IDLE; done=1 for the following cycle; epochs increments unless already all-ones.
- Busy behaviour:
  - start and load_en asserted while busy=1 are ignored, not queued.
  - start held high continuously gives back-to-back epochs. IDLE (with done=1) lasts one cycle, then S_U. Period is 4 cycles.
- Latency: start sampled at edge k → u written at k+1, v at k+2, w at k+3 → done high in cycle k+3..k+4.
- done is registered and is never high while busy=1.
- prop_ok:
  - Combinational from registers and state.
  - Forced to 1 in non-IDLE states, because intermediate states are not architecturally consistent.
- Wrap-around: a counter at 2^WIDTH-1 wraps to 0. This is not an error.
- Unreachable state encodings do not exist: the encoding uses 2 bits with 4 states.

Test Plan:
- Reset, then start at cycle 2 (WIDTH=3) → after done, u=v=w=2; epochs=1; busy high for exactly 3 cycles; phase sequence 1,2,3,0.
- Hold start high for 7 epochs from reset → u=v=w steps 2,3,4,5,6,7,0; prop_ok stays 1 in every IDLE cycle; done pulses every 4 cycles.
- load u=1,v=3,w=0, then start → u<v branch taken: u=4, v=4, w=1; prop_ok=1.
- load u=5,v=2,w=1, then start → neither condition holds: u=3, v=3, w=2. Separately, load u=0,v=1 → prop_ok=0 immediately in IDLE.
- Assert rst in S_V mid-epoch → next cycle u=v=w=1, phase=0, done=0, epochs=0. load_en and start pulsed during S_U/S_V/S_W → no effect.
- load_en and start in the same IDLE cycle → load applied, state stays IDLE, no epoch. Drive 20 epochs with EPW=4 → epochs saturates at 15.
